// File: rtl/fast_pkg.sv
// Shared types and helpers for the FAST corner collection path.
package fast_pkg;
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRIGHT = 2'd1,
        DARK   = 2'd2
    } kp_type_e;

    localparam int DEF_X_W = 11;
    localparam int DEF_Y_W = 11;
    localparam int KP_W    = 2 + DEF_Y_W + DEF_X_W;
    localparam int CNT_W   = 16;

    typedef struct packed {
        kp_type_e             kp_type;
        logic [DEF_Y_W-1:0]   y;
        logic [DEF_X_W-1:0]   x;
    } kp_t;

    function automatic logic is_corner(input logic [7:0] d);
        return (d == 8'd1) || (d == 8'd2);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/fast_corner_collector_fifo.sv
// First-word-fall-through FIFO; push while full is accepted when a pop retires an entry the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fast_corner_collector.sv
// Collects FAST corner classifications into a raster-ordered keypoint stream
// with per-frame accept/drop statistics.
module fast_corner_collector
    import fast_pkg::*;
#(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int BORDER      = 3,
    parameter int X_W         = DEF_X_W,
    parameter int Y_W         = DEF_Y_W,
    parameter int FIFO_DEPTH  = 64,
    parameter int MAX_CORNERS = 500
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_image_vs,
    input  logic                   i_image_hs,
    input  logic                   i_image_en,
    input  logic [7:0]             i_image_data,
    output logic                   o_kp_valid,
    input  logic                   i_kp_ready,
    output logic [2+Y_W+X_W-1:0]   o_kp_data,
    output logic                   o_frame_done,
    output logic [15:0]            o_frame_corners,
    output logic [15:0]            o_frame_drops,
    output logic                   o_overflow
);
    localparam int KPW = 2 + Y_W + X_W;

    typedef struct packed {
        kp_type_e       kp_type;
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x;
    } kp_loc_t;

    logic       s1_vs, s1_vs_d, s1_hs, s1_hs_d, s1_en;
    logic [7:0] s1_data;
    logic       vs_rise, vs_fall, hs_fall;

    // vs history resets high so a reset released mid-frame never looks like a frame start.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_vs   <= 1'b1;
            s1_vs_d <= 1'b1;
            s1_hs   <= 1'b0;
            s1_hs_d <= 1'b0;
            s1_en   <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_vs   <= i_image_vs;
            s1_vs_d <= s1_vs;
            s1_hs   <= i_image_hs;
            s1_hs_d <= s1_hs;
            s1_en   <= i_image_en;
            s1_data <= i_image_data;
        end
    end

    assign vs_rise = s1_vs & ~s1_vs_d;
    assign vs_fall = ~s1_vs & s1_vs_d;
    assign hs_fall = ~s1_hs & s1_hs_d;

    logic           frame_active;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           pix_en;

    assign pix_en = frame_active & s1_hs & s1_en;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            frame_active <= 1'b0;
            x_cnt        <= '0;
            y_cnt        <= '0;
        end else begin
            if (vs_rise)      frame_active <= 1'b1;
            else if (vs_fall) frame_active <= 1'b0;

            if (vs_rise) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (hs_fall) begin
                x_cnt <= '0;
                if (y_cnt != '1) y_cnt <= y_cnt + 1'b1;
            end else if (pix_en && x_cnt != '1) begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    logic x_ok, y_ok, cand;

    assign x_ok = (x_cnt >= X_W'(BORDER)) && (x_cnt < X_W'(IMG_WIDTH - BORDER));
    assign y_ok = (y_cnt >= Y_W'(BORDER)) && (y_cnt < Y_W'(IMG_HEIGHT - BORDER));
    assign cand = pix_en & is_corner(s1_data) & x_ok & y_ok;

    logic    s2_vld;
    kp_loc_t s2_kp;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_vld <= 1'b0;
            s2_kp  <= '0;
        end else begin
            s2_vld <= cand;
            s2_kp  <= '{kp_type: kp_type_e'(s1_data[1:0]), y: y_cnt, x: x_cnt};
        end
    end

    logic [15:0] acc_cnt, drp_cnt, acc_nxt, drp_nxt;
    logic        fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic        cap_hit, fifo_block, ovf_set;

    assign fifo_pop   = o_kp_valid & i_kp_ready;
    assign cap_hit    = (acc_cnt == 16'(MAX_CORNERS));
    assign fifo_block = fifo_full & ~fifo_pop;
    assign fifo_push  = s2_vld & ~cap_hit & ~fifo_block;
    assign ovf_set    = s2_vld & ~cap_hit & fifo_block;
    assign acc_nxt    = fifo_push ? sat_inc(acc_cnt) : acc_cnt;
    assign drp_nxt    = (s2_vld & ~fifo_push) ? sat_inc(drp_cnt) : drp_cnt;

    sync_fifo_fwft #(.WIDTH(KPW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (fifo_push),
        .wdata   (s2_kp),
        .pop     (fifo_pop),
        .rdata   (o_kp_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign o_kp_valid = ~fifo_empty;

    // The stage-2 write lands in the old frame's counts before a vs rise restarts them.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc_cnt         <= '0;
            drp_cnt         <= '0;
            o_overflow      <= 1'b0;
            o_frame_done    <= 1'b0;
            o_frame_corners <= '0;
            o_frame_drops   <= '0;
        end else begin
            o_frame_done <= 1'b0;
            acc_cnt      <= acc_nxt;
            drp_cnt      <= drp_nxt;
            if (ovf_set) o_overflow <= 1'b1;
            if (vs_fall && frame_active) begin
                o_frame_corners <= acc_nxt;
                o_frame_drops   <= drp_nxt;
                o_frame_done    <= 1'b1;
            end
            if (vs_rise) begin
                acc_cnt    <= '0;
                drp_cnt    <= '0;
                o_overflow <= 1'b0;
            end
        end
    end
endmodule

// File: doc/fast_corner_collector.md
Name: fast_corner_collector

Overview:
- Consumes the per-pixel FAST classification stream (0 = none, 1 = bright corner, 2 = dark corner) with its vs/hs/en timing.
- Tracks pixel coordinates and discards corners inside the invalid image border.
- Pushes accepted keypoints {type, y, x} into an internal FWFT FIFO with a valid/ready output.
- Reports per-frame corner, drop and overflow status to the descriptor/NMS stage downstream.

Parameters:
- IMG_WIDTH, 640, active pixels per line
- IMG_HEIGHT, 480, active lines per frame
- BORDER, 3, pixels excluded on each image edge (FAST radius)
- X_W, 11, x coordinate width
- Y_W, 11, y coordinate width
- FIFO_DEPTH, 64, keypoint FIFO entries (power of 2)
- MAX_CORNERS, 500, per-frame cap on accepted corners

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_image_vs  in  1  frame active, high for the whole frame
- i_image_hs  in  1  line active, high for the whole line
- i_image_en  in  1  pixel valid
- i_image_data  in  8  FAST result (0/1/2)
- o_kp_valid  out  1  keypoint available
- i_kp_ready  in  1  downstream accepts keypoint
- o_kp_data  out  2+Y_W+X_W  {type[1:0], y, x}
- o_frame_done  out  1  one-cycle pulse at end of frame
- o_frame_corners  out  16  corners accepted in last frame (latched)
- o_frame_drops  out  16  corners dropped in last frame (latched)
- o_overflow  out  1  sticky FIFO-full drop flag for current frame

Behaviour:
- Reset: i_clk and i_rst_n are the only clock and reset; reset is synchronous, active-low. While i_rst_n=0 at a rising edge, all outputs go to 0: o_kp_valid=0, o_kp_data=0, o_frame_done=0, counters=0, o_overflow=0. The FIFO is emptied and frame_active is cleared.
- Edge detection: vs, hs and en are registered once (stage 1).
  - vs rise: start of frame. Sets frame_active, clears x, y, the running counters and o_overflow.
  - vs fall: end of frame. Clears frame_active.
  - hs fall: end of line. Sets x=0 and y=y+1.
- Pixels before the first vs rise after reset, or outside vs/hs high, are ignored.
- Coordinates: x = index of the current en pixel within the line; it increments after each en and saturates at 2^X_W-1. y saturates at 2^Y_W-1.
- Corner candidate (stage 1) requires all of:
  - frame_active, hs, en and data[7:0] in {1,2}; other values (including 3) are ignored.
  - BORDER <= x < IMG_WIDTH-BORDER.
  - BORDER <= y < IMG_HEIGHT-BORDER.
- Accept rule (stage 2, for each candidate):
  - Running accepted count = MAX_CORNERS: drop, drops+1, no FIFO write.
  - Else FIFO full and no pop in the same cycle: drop, drops+1, o_overflow=1.
  - Else write {type, y, x}, accepted+1.
  - Full with a simultaneous pop is a legal write; occupancy is unchanged.
- Latency: a candidate sampled at edge N is written at edge N+1. With the FIFO empty, o_kp_valid=1 with that data after edge N+2.
- Output handshake, FWFT:
  - o_kp_data is valid whenever o_kp_valid=1; a pop occurs when o_kp_valid && i_kp_ready.
  - o_kp_valid and o_kp_data hold stable while i_kp_ready=0.
  - Order is strictly raster order.
- End of frame, at the vs-fall detect cycle:
  - o_frame_corners and o_frame_drops latch the running counts; o_frame_done=1 for exactly one cycle.
  - The FIFO is not flushed; remaining keypoints drain normally.
- Counters are 16-bit and saturate at 0xFFFF.
- vs rise in the same cycle as a pending stage-2 write: the write completes first; the counters then restart at 0 (the write belongs to the old frame).
- Reset mid-frame discards FIFO contents; no output until the next vs rise.

Decomposition:
- fast_pkg:
  - kp_type_e (NONE=0, BRIGHT=1, DARK=2).
  - kp_t packed struct {type, y, x}.
  - Width localparams derived from X_W/Y_W.
- Sub-module sync_fifo_fwft (WIDTH, DEPTH): push/pop/full/empty, synchronous active-low reset, simultaneous push+pop when full allowed.

Test Plan:
- Reset mid-operation: 20x10 frame (IMG_WIDTH=20, IMG_HEIGHT=10, BORDER=3), reset asserted on line 5 with 3 keypoints queued -> o_kp_valid=0 the cycle after reset. No keypoints until the next vs rise. o_frame_done fires once, at the end of the next frame.
- Single corner and border: data=1 at (x=5,y=4), i_kp_ready=1 -> o_kp_data={1,4,5} valid exactly 2 cycles after input. Border pixels (x=2,y=4), (x=17,y=4) and (x=5,y=7) produce nothing. o_frame_corners=1, o_frame_drops=0.
- Backpressure: i_kp_ready=0, 3 corners of types 1,2,1 -> o_kp_valid held with the first entry stable. Releasing ready yields all 3 in raster order with no loss.
- Overflow: FIFO_DEPTH=4, ready=0, 6 corners -> 4 stored, o_overflow=1, o_frame_drops=2, o_frame_corners=4. o_overflow clears at the next vs rise.
- Cap: MAX_CORNERS=3, 5 corners, ready=1 -> 3 output, o_frame_corners=3, o_frame_drops=2. data=3 pixels are never output.
- Full with pop: FIFO full, ready=1 while a new corner arrives -> the corner is written, occupancy stays 4, drops unchanged.
